// File: rtl/matrix_pkg.sv
// Shared constants and state encoding for the 5x5 matrix sum controller.
package matrix_pkg;

    localparam int ELEM_W = 8;
    localparam int DIM    = 5;
    localparam int ROW_W  = ELEM_W * DIM;
    localparam int MAT_W  = ROW_W * DIM;

    // Index of the final row; row_cnt wraps to zero after this one.
    localparam logic [2:0] LAST_ROW = 3'(DIM - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        CALC   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/matrix_sum_ctrl_sum.sv
// Combinational 5x5 element-wise matrix adder; each sum wraps modulo 256.
module matrix_sum_ctrl_sum
    import matrix_pkg::*;
(
    input  logic [MAT_W-1:0] mat_a,
    input  logic [MAT_W-1:0] mat_b,
    output logic [MAT_W-1:0] sum
);

    // Add every element pair independently; carries never cross elements.
    always_comb begin
        for (int i = 0; i < DIM * DIM; i++) begin
            sum[i*ELEM_W +: ELEM_W] = mat_a[i*ELEM_W +: ELEM_W] + mat_b[i*ELEM_W +: ELEM_W];
        end
    end

endmodule

// File: rtl/matrix_sum_ctrl.sv
// Loads A and B row by row, fires the adder once, then drains the result rows.
module matrix_sum_ctrl #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ELEM_W*DIM-1:0] in_row,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ELEM_W*DIM-1:0] out_row,
    output logic                  out_last,
    output logic                  out_ovf,
    output logic                  busy
);
    import matrix_pkg::*;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_row_cnt;
    logic [2:0]       w_row_cnt_nxt;
    logic [MAT_W-1:0] r_mat_a;
    logic [MAT_W-1:0] r_mat_b;
    logic [MAT_W-1:0] r_res;
    logic             r_ovf;
    logic [MAT_W-1:0] w_sum;
    logic             w_ovf;
    logic             w_wr_a;
    logic             w_wr_b;

    matrix_sum_ctrl_sum sum (
        .mat_a (r_mat_a),
        .mat_b (r_mat_b),
        .sum   (w_sum)
    );

    // Row writes happen only on an accepted beat in the matching load state.
    assign w_wr_a = (r_state == LOAD_A) && in_valid;
    assign w_wr_b = (r_state == LOAD_B) && in_valid;

    // An element wrapped exactly when its modular sum is below its A operand.
    always_comb begin
        w_ovf = 1'b0;
        for (int i = 0; i < DIM * DIM; i++) begin
            if (w_sum[i*ELEM_W +: ELEM_W] < r_mat_a[i*ELEM_W +: ELEM_W]) begin
                w_ovf = 1'b1;
            end
        end
    end

    // Next-state, row counter and handshake decode, from registered state only.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_state_nxt   = r_state;
        w_row_cnt_nxt = r_row_cnt;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        case (r_state)
            LOAD_A, LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (r_row_cnt == LAST_ROW) begin
                        w_row_cnt_nxt = 3'd0;
                        w_state_nxt   = (r_state == LOAD_A) ? LOAD_B : CALC;
                    end else begin
                        w_row_cnt_nxt = r_row_cnt + 3'd1;
                    end
                end
            end
            CALC: begin
                w_state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (r_row_cnt == LAST_ROW) begin
                        w_row_cnt_nxt = 3'd0;
                        w_state_nxt   = LOAD_A;
                    end else begin
                        w_row_cnt_nxt = r_row_cnt + 3'd1;
                    end
                end
            end
            default: w_state_nxt = LOAD_A;
        endcase
    end

    // State, operand, result and overflow registers; reset discards everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: operand/result storage is cleared on reset so a restarted operation never sees stale rows.
            r_state   <= LOAD_A;
            r_row_cnt <= 3'd0;
            r_mat_a   <= '0;
            r_mat_b   <= '0;
            r_res     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_state   <= w_state_nxt;
            r_row_cnt <= w_row_cnt_nxt;
            for (int r = 0; r < DIM; r++) begin
                if (w_wr_a && (r_row_cnt == 3'(r))) r_mat_a[r*ROW_W +: ROW_W] <= in_row;
                if (w_wr_b && (r_row_cnt == 3'(r))) r_mat_b[r*ROW_W +: ROW_W] <= in_row;
            end
            if (r_state == CALC) begin
                r_res <= w_sum;
                r_ovf <= w_ovf;
            end
        end
    end

    // Output row/flags are muxed from registers and forced to zero outside drain.
    always_comb begin
        out_row  = '0;
        out_last = 1'b0;
        out_ovf  = 1'b0;
        if (r_state == DRAIN) begin
            for (int r = 0; r < DIM; r++) begin
                if (r_row_cnt == 3'(r)) out_row = r_res[r*ROW_W +: ROW_W];
            end
            out_last = (r_row_cnt == LAST_ROW);
            out_ovf  = r_ovf;
        end
    end

    assign busy = !((r_state == LOAD_A) && (r_row_cnt == 3'd0));

endmodule

// File: tb/tb_matrix_sum_ctrl.sv
// Directed bench for matrix_sum_ctrl: load/calc/drain sequencing, stalls, wrap and reset.
module tb_matrix_sum_ctrl;

    typedef logic [7:0] mat_t [25];

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] in_row;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_row;
    logic        out_last;
    logic        out_ovf;
    logic        busy;

    int   n_vec;
    int   n_fail;
    mat_t a_m;
    mat_t b_m;
    mat_t e_m;

    matrix_sum_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [39:0] pack_row(input mat_t m, input int r);
        logic [39:0] row;
        for (int c = 0; c < 5; c++) row[c*8 +: 8] = m[r*5 + c];
        return row;
    endfunction

    task automatic send_row(input logic [39:0] row, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_row   = 40'({$urandom(), $urandom()});
            tick();
        end
        check("in_ready_load", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_row   = row;
        tick();
        in_valid = 1'b0;
        in_row   = '0;
    endtask

    // Loads A then B; max_gap > 0 inserts random idle cycles with junk data.
    task automatic load_op(input int max_gap);
        for (int r = 0; r < 5; r++) begin
            send_row(pack_row(a_m, r), (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            if (r == 0) check("busy_after_row0", 64'(busy), 64'(1));
        end
        for (int r = 0; r < 5; r++) begin
            send_row(pack_row(b_m, r), (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
        // One edge after the last B beat the block is in CALC.
        check("calc_out_valid", 64'(out_valid), 64'(0));
        check("calc_in_ready", 64'(in_ready), 64'(0));
        check("calc_busy", 64'(busy), 64'(1));
        tick();
    endtask

    task automatic drain_op(input logic exp_ovf, input int stall_row);
        for (int r = 0; r < 5; r++) begin
            check("drain_valid", 64'(out_valid), 64'(1));
            check("drain_row", 64'(out_row), 64'(pack_row(e_m, r)));
            check("drain_last", 64'(out_last), 64'(r == 4));
            check("drain_ovf", 64'(out_ovf), 64'(exp_ovf));
            if (r == stall_row) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check("stall_valid", 64'(out_valid), 64'(1));
                    check("stall_row_hold", 64'(out_row), 64'(pack_row(e_m, r)));
                    check("stall_last", 64'(out_last), 64'(0));
                end
                out_ready = 1'b1;
            end
            tick();
        end
        check("post_drain_in_ready", 64'(in_ready), 64'(1));
        check("post_drain_busy", 64'(busy), 64'(0));
        check("post_drain_valid", 64'(out_valid), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;

        // Reset values.
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_row", 64'(out_row), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_out_ovf", 64'(out_ovf), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));

        // Basic add: A = i, B = 2i, result 3i.
        for (int i = 0; i < 25; i++) begin
            a_m[i] = 8'(i);
            b_m[i] = 8'(2 * i);
            e_m[i] = 8'(3 * i);
        end
        load_op(0);
        drain_op(1'b0, -1);

        // Wrap-around on element 12 only: 0xF0 + 0x20 = 0x10, overflow flagged.
        for (int i = 0; i < 25; i++) begin
            a_m[i] = 8'h00;
            b_m[i] = 8'h00;
            e_m[i] = 8'h00;
        end
        a_m[12] = 8'hF0;
        b_m[12] = 8'h20;
        e_m[12] = 8'h10;
        load_op(0);
        drain_op(1'b1, -1);

        // Input gaps with junk data and a 3-cycle output stall on row 1.
        for (int i = 0; i < 25; i++) begin
            a_m[i] = 8'(i + 1);
            b_m[i] = 8'h40;
            e_m[i] = 8'(8'h41 + i);
        end
        load_op(3);
        drain_op(1'b0, 1);

        // Back-to-back: FF + 01 wraps every element to zero.
        for (int i = 0; i < 25; i++) begin
            a_m[i] = 8'hFF;
            b_m[i] = 8'h01;
            e_m[i] = 8'h00;
        end
        load_op(0);
        drain_op(1'b1, -1);

        // Mid-operation reset after three B rows, with a beat offered in the reset cycle.
        for (int i = 0; i < 25; i++) begin
            a_m[i] = 8'h77;
            b_m[i] = 8'h99;
        end
        for (int r = 0; r < 5; r++) send_row(pack_row(a_m, r), 0);
        for (int r = 0; r < 3; r++) send_row(pack_row(b_m, r), 0);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_row   = pack_row(b_m, 3);
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_row   = '0;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_out_row", 64'(out_row), 64'(0));

        for (int i = 0; i < 25; i++) begin
            a_m[i] = 8'h05;
            b_m[i] = 8'h05;
            e_m[i] = 8'h0A;
        end
        load_op(0);
        drain_op(1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_sum_ctrl.md
# matrix_sum_ctrl

Sequencing controller for the 5x5 8-bit matrix adder `sum`. It accepts operands A and B as a row-wise stream over a valid/ready input port and fires the combinational adder once. It registers the 25-element result and streams it back out row-by-row over a valid/ready output port. It sits between the host-side transfer logic and the matrix datapath.

## Interface
- `ELEM_W`, default 8: element width. Must match `sum`; only the default is supported.
- `DIM`, default 5: matrix dimension. Only the default is supported.
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: the upstream row beat on `in_row` is valid.
- `in_ready`, out, 1: the block accepts an input beat this cycle.
- `in_row`, in, 40: one matrix row. Column c is in bits [c*8 +: 8].
- `out_valid`, out, 1: `out_row` holds a valid result row.
- `out_ready`, in, 1: downstream accepts the output beat.
- `out_row`, out, 40: one result row, same column packing as `in_row`.
- `out_last`, out, 1: high with `out_valid` on result row 4.
- `out_ovf`, out, 1: during drain, high if any of the 25 element sums wrapped past 255.
- `busy`, out, 1: high in every state except `LOAD_A` with `row_cnt` = 0.

## Operation
- Packing:
  - Element i = r*5 + c lives at matrix bits [i*8 +: 8].
  - Row r maps to matrix bits [r*40 +: 40].
- States:
  - `LOAD_A`:
    - `in_ready` = 1.
    - Each accepted beat (`in_valid` & `in_ready`) writes `mat_a[row_cnt*40 +: 40]` and increments `row_cnt`.
    - On accepting row 4: `row_cnt` <= 0, go to `LOAD_B`.
  - `LOAD_B`:
    - Same as `LOAD_A`, writing `mat_b`.
    - On accepting row 4: go to `CALC`.
  - `CALC`:
    - `in_ready` = 0, `out_valid` = 0.
    - Registers the `sum` output into `res` and the overflow flag into `ovf_reg`.
    - Next state is unconditionally `DRAIN`.
  - `DRAIN`:
    - `out_valid` = 1.
    - `out_row` = `res[row_cnt*40 +: 40]`.
    - `out_last` = (`row_cnt` == 4).
    - `out_ovf` = `ovf_reg`.
    - Each accepted beat (`out_valid` & `out_ready`) increments `row_cnt`.
    - On accepting row 4: `row_cnt` <= 0, go to `LOAD_A`.
- Arithmetic:
  - Element sums are modulo 256, as produced by `sum`.
  - Overflow for element i is (res_i < a_i), unsigned compare.
  - `ovf_reg` is the OR of all 25 overflow terms.
- Stall rules:
  - `in_valid` low in the load states: hold state and `row_cnt`.
  - `out_ready` low in `DRAIN`: hold `out_row`, `out_last`, `out_ovf` and `row_cnt` stable; `out_valid` stays high.
- Input beats never overlap output beats. The block is half-duplex by state.
- Reset takes priority over any handshake in the same cycle, including mid-load and mid-drain. It discards partial operands and results.

## Timing
- Reset values:
  - State `LOAD_A`, `row_cnt` = 0.
  - `mat_a`, `mat_b`, `res` all zero; `ovf_reg` = 0.
  - Outputs: `in_ready` = 1, `out_valid` = 0, `out_row` = 0, `out_last` = 0, `out_ovf` = 0, `busy` = 0.
- Handshake outputs:
  - `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.
  - `out_row`, `out_last` and `out_ovf` are muxed from registers only.
- Latency:
  - Last B row accepted at edge t: `CALC` during cycle t to t+1.
  - `out_valid` first high in the cycle after edge t+1.
  - After the final output beat is accepted, `in_ready` is high the next cycle.
- Best-case throughput is 16 cycles per operation: 10 load + 1 calc + 5 drain.

## Structure
- Shared package `matrix_pkg`:
  - Constants `ELEM_W` = 8, `DIM` = 5, `ROW_W` = 40, `MAT_W` = 200.
  - State enum `LOAD_A`, `LOAD_B`, `CALC`, `DRAIN` (2 bits).
- `row_cnt` is 3 bits and is shared by the load and drain phases.
- One sub-module instance, `sum`: inputs `mat_a` and `mat_b`, output to the `res` register input.
- The overflow reduction is local logic in this block.

## Test plan
- Basic add:
  - Stimulus: A elements = i, B elements = 2i for i = 0..24, `out_ready` held 1.
  - Required: result rows carry elements 3i; `out_last` only on the 5th beat; `out_ovf` = 0; `out_valid` first high 2 cycles after the last B beat.
- Wrap-around:
  - Stimulus: A element 12 = 0xF0, B element 12 = 0x20, all other elements 0.
  - Required: row 2 column 2 = 0x10; `out_ovf` = 1 on all 5 beats.
- Input and output stalls:
  - Stimulus: random `in_valid` gaps; `out_ready` low for 3 cycles on row 1.
  - Required: rows are captured only on handshakes; `out_row` holds row 1 stable until accepted; no row is lost or duplicated.
- Back-to-back operations:
  - Stimulus: second operation with A = all 0xFF, B = all 0x01, started right after the first drain.
  - Required: `in_ready` is high the cycle after the last output beat; all result elements = 0x00; `out_ovf` = 1.
- Mid-operation reset:
  - Stimulus: assert `reset` after 3 B rows, then run a fresh operation with A = B = all 0x05.
  - Required: state returns to `LOAD_A` with `busy` = 0; result elements all 0x0A, with no stale data.
